// File: rtl/div32_seq.sv
// Sequential 32-bit unsigned divider: radix-2 restoring, one quotient bit per cycle.
// Results are registered and held until the next start, an abort or reset.
module div32_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_start,
    input  logic        op_clear,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        op_busy,
    output logic        op_done,
    output logic        div_by_zero
);

    localparam int unsigned W    = 32;
    localparam int unsigned CW   = 5;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [W-1:0]  q_work, q_work_n;
    logic [W-1:0]  r_work, r_work_n;
    logic [W-1:0]  dvs, dvs_n;
    logic [W-1:0]  quotient_n, remainder_n;
    logic          busy_n, done_n, dbz_n;
    logic [W:0]    trial, diff;
    logic [W-1:0]  step_r;
    logic          step_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            q_work      <= '0;
            r_work      <= '0;
            dvs         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            op_busy     <= 1'b0;
            op_done     <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            q_work      <= q_work_n;
            r_work      <= r_work_n;
            dvs         <= dvs_n;
            quotient    <= quotient_n;
            remainder   <= remainder_n;
            op_busy     <= busy_n;
            op_done     <= done_n;
            div_by_zero <= dbz_n;
        end
    end

    // One restoring step; the 33-bit trial keeps divisors >= 2^31 from overflowing
    always_comb begin
        trial  = {r_work, q_work[W-1]};
        diff   = trial - {1'b0, dvs};
        step_q = ~diff[W];
        step_r = step_q ? diff[W-1:0] : trial[W-1:0];
    end

    // Next-state and next-register logic
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        q_work_n    = q_work;
        r_work_n    = r_work;
        dvs_n       = dvs;
        quotient_n  = quotient;
        remainder_n = remainder;
        dbz_n       = div_by_zero;

        if (op_clear) begin
            state_n     = IDLE;
            cnt_n       = '0;
            quotient_n  = '0;
            remainder_n = '0;
            dbz_n       = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (op_start) begin
                        state_n  = EXEC;
                        cnt_n    = '0;
                        q_work_n = dividend;
                        r_work_n = '0;
                        dvs_n    = divisor;
                        dbz_n    = 1'b0;
                    end
                end
                EXEC: begin
                    if (dvs == '0) begin
                        // q_work still holds the untouched dividend here
                        state_n     = DONE;
                        quotient_n  = '1;
                        remainder_n = q_work;
                        dbz_n       = 1'b1;
                    end else begin
                        q_work_n = {q_work[W-2:0], step_q};
                        r_work_n = step_r;
                        cnt_n    = CW'(cnt + CW'(1));
                        if (cnt == LAST) begin
                            state_n     = DONE;
                            quotient_n  = {q_work[W-2:0], step_q};
                            remainder_n = step_r;
                            dbz_n       = 1'b0;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        busy_n = (state_n == EXEC);
        done_n = (state_n == DONE);
    end

endmodule

// File: tb/tb_div32_seq.sv
// Directed bench for div32_seq: expected results are queued at each start and
// checked against the DUT when op_done rises.
module tb_div32_seq;

    logic        clk;
    logic        reset_n;
    logic        op_start;
    logic        op_clear;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        op_busy;
    logic        op_done;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
        int          busy;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    div32_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op_start   (op_start),
        .op_clear   (op_clear),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .op_busy    (op_busy),
        .op_done    (op_done),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start; returns sampled just after the accepting edge
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
    endtask

    // Start a division, queue its expected result, optionally pulse a stray start mid-run
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int ignore_at);
        exp_t        e;
        exp_t        got;
        logic [31:0] prev_q;
        logic [31:0] prev_r;
        int          lat;
        int          busy_cnt;
        bit          hold_ok;
        e.dbz  = (b == 32'd0);
        e.q    = e.dbz ? 32'hFFFF_FFFF : a / b;
        e.r    = e.dbz ? a : a % b;
        e.lat  = e.dbz ? 1 : 32;
        e.busy = e.dbz ? 1 : 32;
        sb.push_back(e);
        prev_q  = quotient;
        prev_r  = remainder;
        hold_ok = 1'b1;
        issue(a, b);
        chk({tag, ".done_fall"}, 32'(op_done), 32'd0);
        chk({tag, ".dbz_clear"}, 32'(div_by_zero), 32'd0);
        busy_cnt = int'(op_busy);
        lat      = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (lat == ignore_at) begin
                dividend = 32'd50;
                divisor  = 32'd5;
                op_start = 1'b1;
            end else begin
                op_start = 1'b0;
            end
            @(posedge clk);
            #1;
            op_start = 1'b0;
            lat++;
            if (op_done) break;
            busy_cnt += int'(op_busy);
            if (quotient !== prev_q || remainder !== prev_r) hold_ok = 1'b0;
        end
        chk({tag, ".done_seen"}, 32'(op_done), 32'd1);
        got = sb.pop_front();
        chk({tag, ".latency"}, 32'(lat), 32'(got.lat));
        chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(got.busy));
        chk({tag, ".busy_low"}, 32'(op_busy), 32'd0);
        chk({tag, ".quotient"}, quotient, got.q);
        chk({tag, ".remainder"}, remainder, got.r);
        chk({tag, ".dbz"}, 32'(div_by_zero), 32'(got.dbz));
        chk({tag, ".outputs_held"}, 32'(hold_ok), 32'd1);
    endtask

    // Abort a run after 16 steps via op_clear or reset_n, then confirm nothing completes
    task automatic abort_op(input string tag, input bit use_reset);
        bit no_done;
        issue(32'd1000, 32'd3);
        repeat (16) @(posedge clk);
        @(negedge clk);
        if (use_reset) reset_n = 1'b0;
        else           op_clear = 1'b1;
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        op_clear = 1'b0;
        chk({tag, ".quotient"}, quotient, 32'd0);
        chk({tag, ".remainder"}, remainder, 32'd0);
        chk({tag, ".busy"}, 32'(op_busy), 32'd0);
        chk({tag, ".done"}, 32'(op_done), 32'd0);
        chk({tag, ".dbz"}, 32'(div_by_zero), 32'd0);
        no_done = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (op_done || op_busy) no_done = 1'b0;
        end
        chk({tag, ".stays_idle"}, 32'(no_done), 32'd1);
    endtask

    initial begin
        reset_n  = 1'b0;
        op_start = 1'b0;
        op_clear = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.quotient", quotient, 32'd0);
        chk("reset.remainder", remainder, 32'd0);
        chk("reset.busy", 32'(op_busy), 32'd0);
        chk("reset.done", 32'(op_done), 32'd0);
        chk("reset.dbz", 32'(div_by_zero), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        run_op("d100_7", 32'd100, 32'd7, -1);
        run_op("dmax_1", 32'hFFFF_FFFF, 32'd1, -1);
        run_op("dmax_msb", 32'hFFFF_FFFF, 32'h8000_0000, -1);
        run_op("d5_10", 32'd5, 32'd10, -1);
        run_op("d1234_0", 32'd1234, 32'd0, -1);
        run_op("ignore_start", 32'd100, 32'd7, 10);
        run_op("restart_done", 32'd50, 32'd5, -1);

        abort_op("clear_mid", 1'b0);
        run_op("d7_2", 32'd7, 32'd2, -1);
        abort_op("reset_mid", 1'b1);
        run_op("d9_2", 32'd9, 32'd2, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
